// File: rtl/acc_job_sched.sv
// Round-robin job scheduler sharing one summing accumulator between two requesters.
// Optional stall watchdog: define ACC_SCHED_TIMEOUT_EN.
module acc_job_sched #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req0_req,
  input  logic              req1_req,
  input  logic [DATA_W-1:0] req0_len_value,
  input  logic [DATA_W-1:0] req1_len_value,
  output logic              req0_gnt,
  output logic              req1_gnt,
  input  logic [DATA_W-1:0] req0_din_value,
  input  logic [DATA_W-1:0] req1_din_value,
  input  logic              req0_din_en,
  input  logic              req1_din_en,
  output logic              req0_din_rdy,
  output logic              req1_din_rdy,
  input  logic              req0_resp_en,
  input  logic              req1_resp_en,
  output logic              req0_resp_rdy,
  output logic              req1_resp_rdy,
  output logic [DATA_W-1:0] resp_value,
  output logic              resp_err,
  output logic [DATA_W-1:0] acc_len_value,
  output logic              acc_len_en,
  input  logic              acc_len_rdy,
  output logic [DATA_W-1:0] acc_din_value,
  output logic              acc_din_en,
  input  logic              acc_din_rdy,
  output logic              acc_dout_en,
  input  logic [DATA_W-1:0] acc_dout_value,
  input  logic              acc_dout_rdy
);

  typedef enum logic [2:0] {IDLE, PROG, DATA, DRAIN, RESP} state_e;

  state_e            state_q;
  logic [1:0]        gnt_q;
  logic              last_q;
  logic [DATA_W-1:0] len_q;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] resp_value_q;

  logic              anyReq;
  logic              pick1;
  logic [DATA_W-1:0] winLen;
  logic              respTake;

  // On a tie the requester that was not served last wins.
  assign anyReq   = req0_req | req1_req;
  assign pick1    = req1_req & (~req0_req | ~last_q);
  assign winLen   = pick1 ? req1_len_value : req0_len_value;
  assign respTake = gnt_q[1] ? req1_resp_en : req0_resp_en;

  assign req0_gnt      = gnt_q[0];
  assign req1_gnt      = gnt_q[1];
  assign acc_len_value = len_q;
  assign acc_len_en    = (state_q == PROG) & acc_len_rdy;
  assign req0_din_rdy  = (state_q == DATA) & gnt_q[0] & acc_din_rdy;
  assign req1_din_rdy  = (state_q == DATA) & gnt_q[1] & acc_din_rdy;
  assign acc_din_value = gnt_q[1] ? req1_din_value : req0_din_value;
  assign acc_din_en    = (req0_din_rdy & req0_din_en) | (req1_din_rdy & req1_din_en);
  assign acc_dout_en   = (state_q == DRAIN) & acc_dout_rdy;
  assign req0_resp_rdy = (state_q == RESP) & gnt_q[0];
  assign req1_resp_rdy = (state_q == RESP) & gnt_q[1];
  assign resp_value    = resp_value_q;

`ifdef ACC_SCHED_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_q;
  logic          resp_err_q;
  logic          busy;
  logic          handshake;

  assign busy      = (state_q == PROG) | (state_q == DATA) | (state_q == DRAIN);
  assign handshake = acc_len_en | acc_din_en | acc_dout_en;
  assign resp_err  = resp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign resp_err       = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      last_q       <= 1'b1;
      len_q        <= '0;
      count_q      <= '0;
      resp_value_q <= '0;
`ifdef ACC_SCHED_TIMEOUT_EN
      stall_q      <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            gnt_q <= {pick1, ~pick1};
            len_q <= winLen;
            if (winLen == '0) begin
              resp_value_q <= '0;
`ifdef ACC_SCHED_TIMEOUT_EN
              resp_err_q   <= 1'b0;
`endif
              state_q      <= RESP;
            end else begin
              state_q <= PROG;
            end
          end
        end
        PROG: begin
          if (acc_len_en) begin
            count_q <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          // Exit is tested before incrementing, so len 255 never wraps the count.
          if (acc_din_en) begin
            if (count_q == len_q - DATA_W'(1)) state_q <= DRAIN;
            else count_q <= count_q + DATA_W'(1);
          end
        end
        DRAIN: begin
          if (acc_dout_en) begin
            resp_value_q <= acc_dout_value;
`ifdef ACC_SCHED_TIMEOUT_EN
            resp_err_q   <= 1'b0;
`endif
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (respTake) begin
            gnt_q   <= 2'b00;
            last_q  <= gnt_q[1];
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef ACC_SCHED_TIMEOUT_EN
      // A stalled job is forced to a response; later assignments override the case above.
      if (busy && !handshake) begin
        if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
          stall_q      <= '0;
          resp_err_q   <= 1'b1;
          resp_value_q <= '0;
          state_q      <= RESP;
        end else begin
          stall_q <= stall_q + SW'(1);
        end
      end else begin
        stall_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_acc_job_sched.sv
// Self-checking bench for acc_job_sched: table-driven jobs, reset/timeout sequences,
// and randomized jobs checked against a job-level reference model.
module tb_acc_job_sched;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       req0_req, req1_req;
  logic [7:0] req0_len_value, req1_len_value;
  logic       req0_gnt, req1_gnt;
  logic [7:0] req0_din_value, req1_din_value;
  logic       req0_din_en, req1_din_en;
  logic       req0_din_rdy, req1_din_rdy;
  logic       req0_resp_en, req1_resp_en;
  logic       req0_resp_rdy, req1_resp_rdy;
  logic [7:0] resp_value;
  logic       resp_err;
  logic [7:0] acc_len_value;
  logic       acc_len_en, acc_len_rdy;
  logic [7:0] acc_din_value;
  logic       acc_din_en, acc_din_rdy;
  logic       acc_dout_en;
  logic [7:0] acc_dout_value;
  logic       acc_dout_rdy;

  acc_job_sched #(.DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0_req(req0_req), .req1_req(req1_req),
    .req0_len_value(req0_len_value), .req1_len_value(req1_len_value),
    .req0_gnt(req0_gnt), .req1_gnt(req1_gnt),
    .req0_din_value(req0_din_value), .req1_din_value(req1_din_value),
    .req0_din_en(req0_din_en), .req1_din_en(req1_din_en),
    .req0_din_rdy(req0_din_rdy), .req1_din_rdy(req1_din_rdy),
    .req0_resp_en(req0_resp_en), .req1_resp_en(req1_resp_en),
    .req0_resp_rdy(req0_resp_rdy), .req1_resp_rdy(req1_resp_rdy),
    .resp_value(resp_value), .resp_err(resp_err),
    .acc_len_value(acc_len_value), .acc_len_en(acc_len_en), .acc_len_rdy(acc_len_rdy),
    .acc_din_value(acc_din_value), .acc_din_en(acc_din_en), .acc_din_rdy(acc_din_rdy),
    .acc_dout_en(acc_dout_en), .acc_dout_value(acc_dout_value), .acc_dout_rdy(acc_dout_rdy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         r0;
    bit         r1;
    logic [7:0] len0;
    logic [7:0] len1;
    logic [7:0] base0;
    logic [7:0] base1;
    int         mode;
    int         expWin;
    logic [7:0] expSum;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Job-level bookkeeping shared by the cycle driver and the job runner
  logic [7:0] byteQ[$];
  int         curWin;
  int         lenXfers, dinXfers, doutXfers;
  logic [7:0] lenVal;
  bit         dataBad, protoBad, otherBad;
  bit         accArmed;
  int         accLeft;
  logic [7:0] accSum;
  bit         toggleBit;
  int         lowStreak;
  int         lastG;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearJob();
    byteQ.delete();
    lenXfers = 0; dinXfers = 0; doutXfers = 0; lenVal = 8'h00;
    dataBad = 0; protoBad = 0; otherBad = 0;
    accArmed = 0; accLeft = 0; accSum = 8'h00;
    lowStreak = 0;
  endtask

  // One clock cycle: modes 0 always-ready, 1 toggling, 2 random (max 3 low), 3 dout stuck low
  task automatic stepCycle(input int mode);
    bit go;
    case (mode)
      1: begin toggleBit = ~toggleBit; go = toggleBit; end
      2: begin
        go = ($urandom_range(0, 1) == 1) || (lowStreak >= 3);
        lowStreak = go ? 0 : lowStreak + 1;
      end
      default: go = 1'b1;
    endcase
    acc_len_rdy    = go;
    acc_din_rdy    = go;
    acc_dout_rdy   = (mode != 3) && go && accArmed && (accLeft == 0);
    acc_dout_value = accSum;
    #1;
    if (curWin == 0) begin
      req0_din_en    = req0_din_rdy && (byteQ.size() > 0);
      req0_din_value = (byteQ.size() > 0) ? byteQ[0] : 8'h00;
    end else begin
      req1_din_en    = req1_din_rdy && (byteQ.size() > 0);
      req1_din_value = (byteQ.size() > 0) ? byteQ[0] : 8'h00;
    end
    #1;
    if ((acc_len_en && acc_din_en) || (acc_len_en && !acc_len_rdy) ||
        (acc_din_en && !acc_din_rdy) || (acc_dout_en && !acc_dout_rdy))
      protoBad = 1;
    if (curWin == 0 ? (req1_din_rdy || req1_resp_rdy) : (req0_din_rdy || req0_resp_rdy))
      otherBad = 1;
    if (acc_len_en && acc_len_rdy) begin
      lenXfers++;
      lenVal   = acc_len_value;
      accArmed = 1;
      accLeft  = int'(acc_len_value);
      accSum   = 8'h00;
    end
    if (acc_din_en && acc_din_rdy) begin
      dinXfers++;
      if (byteQ.size() == 0) dataBad = 1;
      else begin
        if (acc_din_value !== byteQ[0]) dataBad = 1;
        void'(byteQ.pop_front());
      end
      accSum  = accSum + acc_din_value;
      accLeft = accLeft - 1;
    end
    if (acc_dout_en && acc_dout_rdy) doutXfers++;
    @(negedge CLK);
    req0_din_en = 1'b0;
    req1_din_en = 1'b0;
  endtask

  task automatic waitGrant(output bit got);
    int n = 0;
    while (!(req0_gnt || req1_gnt) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    got = req0_gnt || req1_gnt;
  endtask

  task automatic loadBytes(input logic [7:0] len, input logic [7:0] base);
    for (int k = 0; k < int'(len); k++) byteQ.push_back(base + 8'(k));
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    bit got, seen;
    int cyc;
    logic [7:0] len;
    clearJob();
    req0_req = v.r0; req1_req = v.r1;
    req0_len_value = v.len0; req1_len_value = v.len1;
    waitGrant(got);
    checkOutput({tag, ".gnt"}, {req1_gnt, req0_gnt}, (v.expWin == 1) ? 2'b10 : 2'b01);
    req0_req = 1'b0; req1_req = 1'b0;
    curWin = req1_gnt ? 1 : 0;
    len = (curWin == 1) ? v.len1 : v.len0;
    loadBytes(len, (curWin == 1) ? v.base1 : v.base0);
    cyc = 0; seen = 0;
    while (!seen && cyc < 3000) begin
      if ((curWin == 0) ? req0_resp_rdy : req1_resp_rdy) seen = 1;
      else begin stepCycle(v.mode); cyc++; end
    end
    checkOutput({tag, ".resp_rdy"}, seen, 1);
    if (len == 8'h00) checkOutput({tag, ".zero_latency"}, (cyc <= 2), 1);
    else checkOutput({tag, ".len_value"}, lenVal, len);
    checkOutput({tag, ".resp_value"}, resp_value, v.expSum);
    checkOutput({tag, ".resp_err"}, resp_err, 0);
    checkOutput({tag, ".len_xfers"}, lenXfers, (len == 8'h00) ? 0 : 1);
    checkOutput({tag, ".din_xfers"}, dinXfers, int'(len));
    checkOutput({tag, ".dout_xfers"}, doutXfers, (len == 8'h00) ? 0 : 1);
    checkOutput({tag, ".din_data"}, dataBad, 0);
    checkOutput({tag, ".protocol"}, protoBad, 0);
    checkOutput({tag, ".other_idle"}, otherBad, 0);
    if (seen) begin
      if (curWin == 0) req0_resp_en = 1'b1; else req1_resp_en = 1'b1;
      @(negedge CLK);
      req0_resp_en = 1'b0; req1_resp_en = 1'b0;
      checkOutput({tag, ".gnt_clear"}, {req1_gnt, req0_gnt, req1_resp_rdy, req0_resp_rdy}, 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[9];
    vec_t rv;
    bit got;
    int n;
    tbl[0] = '{1, 1, 8'd2,   8'd2, 8'h10, 8'h20, 0, 0, 8'h21};
    tbl[1] = '{0, 1, 8'd0,   8'd2, 8'h00, 8'h20, 2, 1, 8'h41};
    tbl[2] = '{1, 1, 8'd2,   8'd2, 8'h30, 8'h40, 1, 0, 8'h61};
    tbl[3] = '{1, 0, 8'd3,   8'd0, 8'h01, 8'h00, 0, 0, 8'h06};
    tbl[4] = '{0, 1, 8'd0,   8'd0, 8'h00, 8'h00, 0, 1, 8'h00};
    tbl[5] = '{1, 1, 8'd1,   8'd1, 8'hFF, 8'h05, 2, 0, 8'hFF};
    tbl[6] = '{1, 1, 8'd4,   8'd4, 8'h80, 8'h7E, 2, 1, 8'hFE};
    tbl[7] = '{1, 0, 8'd255, 8'd0, 8'h00, 8'h00, 0, 0, 8'h81};
    tbl[8] = '{1, 0, 8'd4,   8'd0, 8'h02, 8'h00, 1, 0, 8'h0E};

    RST_N = 1'b0;
    req0_req = 0; req1_req = 0; req0_len_value = 0; req1_len_value = 0;
    req0_din_value = 0; req1_din_value = 0; req0_din_en = 0; req1_din_en = 0;
    req0_resp_en = 0; req1_resp_en = 0;
    acc_len_rdy = 0; acc_din_rdy = 0; acc_dout_rdy = 0; acc_dout_value = 0;
    toggleBit = 0; curWin = 0;
    clearJob();
    repeat (3) @(negedge CLK);
    checkOutput("reset.gnt", {req1_gnt, req0_gnt}, 0);
    checkOutput("reset.outs", {acc_len_en, acc_din_en, acc_dout_en, req0_din_rdy, req1_din_rdy,
                               req0_resp_rdy, req1_resp_rdy, resp_err}, 0);
    checkOutput("reset.values", {resp_value, acc_len_value}, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) applyStimulus(tbl[i], $sformatf("tbl%0d", i));

    // Reset in the middle of a 5-byte job after two bytes have streamed
    clearJob();
    req0_req = 1; req0_len_value = 8'd5;
    waitGrant(got);
    req0_req = 0; curWin = 0;
    loadBytes(8'd5, 8'h50);
    n = 0;
    while (dinXfers < 2 && n < 100) begin stepCycle(0); n++; end
    checkOutput("midrst.din_xfers", dinXfers, 2);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("midrst.gnt", {req1_gnt, req0_gnt}, 0);
    checkOutput("midrst.outs", {acc_len_en, acc_din_en, acc_dout_en, req0_din_rdy,
                                req0_resp_rdy, resp_err}, 0);
    checkOutput("midrst.values", {resp_value, acc_len_value}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    applyStimulus('{1, 1, 8'd1, 8'd1, 8'h11, 8'h22, 0, 0, 8'h11}, "postrst");

    // Accumulator result never becomes valid
    clearJob();
    req0_req = 1; req0_len_value = 8'd1;
    waitGrant(got);
    req0_req = 0; curWin = 0;
    loadBytes(8'd1, 8'h09);
    for (int i = 0; i < 40; i++) begin
      if (req0_resp_rdy) break;
      stepCycle(3);
    end
    checkOutput("stuck.din_xfers", dinXfers, 1);
`ifdef ACC_SCHED_TIMEOUT_EN
    checkOutput("stuck.resp_rdy", req0_resp_rdy, 1);
    checkOutput("stuck.resp_err", resp_err, 1);
    checkOutput("stuck.resp_value", resp_value, 0);
`else
    checkOutput("stuck.resp_rdy", req0_resp_rdy, 0);
    checkOutput("stuck.resp_err", resp_err, 0);
`endif
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    lastG = 1;

    // Randomized jobs against the round-robin / summing reference model
    for (int j = 0; j < 40; j++) begin
      int pat;
      logic [7:0] s;
      logic [7:0] l;
      logic [7:0] b;
      pat = $urandom_range(1, 3);
      rv.r0 = pat[0]; rv.r1 = pat[1];
      rv.len0 = 8'($urandom_range(0, 12)); rv.len1 = 8'($urandom_range(0, 12));
      rv.base0 = 8'($urandom); rv.base1 = 8'($urandom);
      rv.mode = $urandom_range(0, 2);
      if (pat == 3) rv.expWin = (lastG == 1) ? 0 : 1;
      else rv.expWin = (pat == 2) ? 1 : 0;
      l = (rv.expWin == 1) ? rv.len1 : rv.len0;
      b = (rv.expWin == 1) ? rv.base1 : rv.base0;
      s = 8'h00;
      for (int k = 0; k < int'(l); k++) s = s + b + 8'(k);
      rv.expSum = s;
      lastG = rv.expWin;
      applyStimulus(rv, $sformatf("rnd%0d", j));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
